// File: rtl/bcd_a_binario.sv
// Sequential packed-BCD to binary converter: one digit per clock, most significant digit first.
// Digits above 9 are flagged at capture time and skip the conversion entirely.
module bcd_a_binario #(
  parameter int DIGITOS = 4,
  parameter int ANCHO   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*DIGITOS-1:0]   BCD_in,
  output logic [ANCHO-1:0]       bin_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int CW = $clog2(DIGITOS + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t               state, state_n;
  logic [4*DIGITOS-1:0] sh, sh_n;
  logic [ANCHO-1:0]     acc, acc_n, acc_step, bin_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 busy_n, done_n, error_n, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (BCD_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // acc*10 as two shifts; ANCHO is sized so this never overflows.
  assign acc_step = (acc << 3) + (acc << 1) + ANCHO'(sh[4*DIGITOS-1 -: 4]);

  always_comb begin
    state_n = state;
    sh_n    = sh;
    acc_n   = acc;
    cnt_n   = cnt;
    bin_n   = bin_out;
    busy_n  = busy;
    done_n  = 1'b0;
    error_n = error;
    unique case (state)
      IDLE: begin
        if (start) begin
          sh_n  = BCD_in;
          acc_n = '0;
          cnt_n = '0;
          if (bad_digit) begin
            state_n = FIN;
            error_n = 1'b1;
            bin_n   = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = CONV;
            busy_n  = 1'b1;
          end
        end
      end
      CONV: begin
        acc_n = acc_step;
        sh_n  = sh << 4;
        if (cnt == CW'(DIGITOS - 1)) begin
          state_n = FIN;
          bin_n   = acc_step;
          error_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      bin_out <= bin_n;
      busy    <= busy_n;
      done    <= done_n;
      error   <= error_n;
    end
  end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Directed and back-to-back random checks for bcd_a_binario (DIGITOS=4, ANCHO=14).
module tb_bcd_a_binario;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] BCD_in;
  logic [13:0] bin_out;
  logic        busy, done, error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bcd_a_binario #(.DIGITOS(4), .ANCHO(14)) dut (
    .clk(clk), .rst(rst), .start(start), .BCD_in(BCD_in),
    .bin_out(bin_out), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issues a one-cycle start and reports what was seen up to the done pulse and the cycle after.
  task automatic do_conv(input logic [15:0] bcd, output int lat, output int busy_cyc,
                         output logic [13:0] bin, output logic err, output logic done_after);
    @(negedge clk);
    BCD_in = bcd;
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) lat = -1;
    bin = bin_out;
    err = error;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; BCD_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bin_out, busy, done, error} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got bin=%h busy=%b done=%b err=%b, want all 0", bin_out, busy, done, error);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_conv(input logic [15:0] bcd, input logic [13:0] exp_bin, input string name);
    int lat, bc; logic [13:0] b; logic e, da;
    do_conv(bcd, lat, bc, b, e, da);
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL %s_latency: got %0d, want 4", name, lat); end
    n_cmp++;
    if (bc !== 4) begin n_err++; $display("FAIL %s_busy_cycles: got %0d, want 4", name, bc); end
    n_cmp++;
    if (b !== exp_bin) begin n_err++; $display("FAIL %s_bin: got %0d, want %0d", name, b, exp_bin); end
    n_cmp++;
    if (e !== 1'b0) begin n_err++; $display("FAIL %s_error: got %b, want 0", name, e); end
    n_cmp++;
    if (da !== 1'b0) begin n_err++; $display("FAIL %s_done_width: done still %b, want 0", name, da); end
  endtask

  task automatic test_invalid();
    int lat, bc; logic [13:0] b; logic e, da;
    do_conv(16'h12A4, lat, bc, b, e, da);
    n_cmp++;
    if (lat !== 0) begin n_err++; $display("FAIL invalid_latency: got %0d, want 0", lat); end
    n_cmp++;
    if (bc !== 0) begin n_err++; $display("FAIL invalid_busy: got %0d busy cycles, want 0", bc); end
    n_cmp++;
    if (e !== 1'b1) begin n_err++; $display("FAIL invalid_error: got %b, want 1", e); end
    n_cmp++;
    if (b !== 14'd0) begin n_err++; $display("FAIL invalid_bin: got %0d, want 0", b); end
    n_cmp++;
    if (da !== 1'b0) begin n_err++; $display("FAIL invalid_done_width: done still %b, want 0", da); end
    test_conv(16'h0042, 14'd42, "after_invalid");
  endtask

  task automatic test_ignore_start();
    int pulses = 0; logic [13:0] b = '0; int at = -1;
    @(negedge clk); BCD_in = 16'h0100; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; BCD_in = 16'h5555;
    @(posedge clk); #1; start = 1'b0; BCD_in = 16'h0000;
    for (int k = 3; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; b = bin_out; at = k; end
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL ignore_start_pulses: got %0d, want 1", pulses); end
    n_cmp++;
    if (at !== 4) begin n_err++; $display("FAIL ignore_start_latency: got %0d, want 4", at); end
    n_cmp++;
    if (b !== 14'd100) begin n_err++; $display("FAIL ignore_start_bin: got %0d, want 100", b); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clk); BCD_in = 16'h8765; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bin_out, busy, done, error} !== 17'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got bin=%0d busy=%b done=%b err=%b, want all 0", bin_out, busy, done, error);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles, want 0", pulses); end
    test_conv(16'h0007, 14'd7, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[1000];
    int          exp_v[1000];
    int          d, last, t;
    for (int i = 0; i < 1000; i++) begin
      exp_v[i] = 0;
      for (int j = 3; j >= 0; j--) begin
        d = $urandom_range(9, 0);
        vals[i][4*j +: 4] = 4'(d);
        exp_v[i] = exp_v[i] * 10 + d;
      end
    end
    @(negedge clk); BCD_in = vals[0]; start = 1'b1;
    last = 0;
    for (int i = 0; i < 1000; i++) begin
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!done && t < 20);
      n_cmp++;
      if (!done) begin
        n_err++;
        $display("FAIL b2b_timeout: conversion %0d gave no done, want done", i);
        break;
      end
      if (i + 1 < 1000) BCD_in = vals[i+1];
      n_cmp++;
      if (bin_out !== 14'(exp_v[i]) || error !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_value[%0d]: got %0d err=%b, want %0d err=0", i, bin_out, error, exp_v[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - last !== 6) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d, want 6", i, cyc - last); end
      end
      last = cyc;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_conv(16'h1234, 14'h04D2, "conv_1234");
    test_conv(16'h9999, 14'h270F, "conv_9999");
    test_conv(16'h0000, 14'd0, "conv_0000");
    test_invalid();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_a_binario.md
BCD_A_BINARIO -- requirements
Module: bcd_a_binario

Interface
REQ-001 The block SHALL have parameter DIGITOS, default 4: number of packed BCD digits at the input.
REQ-002 The block SHALL have parameter ANCHO, default 14: binary output width, with ANCHO >= ceil(log2(10^DIGITOS)).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled on a rising edge.
REQ-006 The block SHALL have port BCD_in, input, 4*DIGITOS bits: packed BCD, most significant digit in the top nibble.
REQ-007 The block SHALL have port bin_out, output, ANCHO bits: registered binary result.
REQ-008 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port error, output, 1 bit: last accepted input contained a digit > 9.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, CONV and FIN.
REQ-012 In IDLE, start=1 at edge E0 SHALL capture BCD_in into an internal shift register, clear the accumulator and clear the digit counter.
REQ-013 If every captured nibble is <= 9, the state SHALL go IDLE->CONV at E0 and busy SHALL be 1 from E0.
REQ-014 If any captured nibble is > 9, the state SHALL go IDLE->FIN at E0 with error=1, bin_out=0 and done=1 from E0, and no CONV cycles SHALL occur.
REQ-015 In CONV, each edge SHALL perform acc <= acc*10 + top nibble and shift the register left by 4, processing the most significant digit first.
REQ-016 The multiply by 10 SHALL be computed as (acc<<3)+(acc<<1) at ANCHO bits; no overflow is possible within the ANCHO bound.
REQ-017 CONV SHALL last exactly DIGITOS cycles, counted by the digit counter from 0 to DIGITOS-1.
REQ-018 At edge E0+DIGITOS the state SHALL go CONV->FIN, bin_out SHALL load the final accumulator value, error SHALL be set to 0, busy SHALL be set to 0 and done SHALL be set to 1.
REQ-019 FIN SHALL last exactly one cycle, then go FIN->IDLE with done returning to 0.
REQ-020 start SHALL be ignored in CONV and FIN, and SHALL have no effect on the captured data or the latency.
REQ-021 bin_out and error SHALL change only on entry to FIN or on reset, and SHALL hold their values in all other cycles.
REQ-022 BCD_in SHALL be don't-care except at the edge where start is accepted.
REQ-023 A start held high continuously SHALL start a new conversion in each IDLE cycle, giving back-to-back conversions every DIGITOS+2 cycles.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, bin_out=0, busy=0, done=0, error=0, and clear the accumulator, shift register and counter.
REQ-025 rst SHALL take priority over start and over any in-progress conversion.
REQ-026 A reset during CONV or FIN SHALL abort the conversion with no done pulse and no update of bin_out.
REQ-027 The first start accepted after rst deasserts SHALL behave exactly as in REQ-012 to REQ-019.

Verification
REQ-028 The bench SHALL apply BCD_in=16'h1234 with a 1-cycle start and require busy for 4 cycles, then done for 1 cycle with bin_out=1234 (14'h04D2) and error=0, exactly 4 edges after E0.
REQ-029 The bench SHALL apply BCD_in=16'h9999 and require bin_out=9999 (14'h270F); it SHALL apply BCD_in=16'h0000 and require bin_out=0 with done pulsed.
REQ-030 The bench SHALL apply BCD_in=16'h12A4 and require done=1 and error=1 at E0 with bin_out=0 and busy never asserted; a following 16'h0042 SHALL give error=0 and bin_out=42.
REQ-031 The bench SHALL pulse start with BCD_in=16'h5555 during the second CONV cycle of a 16'h0100 conversion and require a single done pulse with bin_out=100.
REQ-032 The bench SHALL assert rst during the third CONV cycle of 16'h8765 and require no done pulse, all outputs 0, and a following 16'h0007 to give bin_out=7.
REQ-033 The bench SHALL apply 1000 random valid BCD_in values with start held high and compare each bin_out on done against a reference model, requiring a DIGITOS+2-cycle period between done pulses.
